// File: rtl/pc_unit_if.sv
// Control-unit <-> PC unit bundle: next-PC select, targets, fetch address and RAS status.
interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  logic                         stall;
  logic [2:0]                   PCsrc;
  logic [WIDTH-1:0]             Result;
  logic [WIDTH-1:0]             ImmOp;
  logic [WIDTH-1:0]             PC;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_overflow;
  logic                         ras_underflow;
  logic                         misaligned;

  modport master (
    output stall, PCsrc, Result, ImmOp,
    input  PC, ras_count, ras_overflow, ras_underflow, misaligned
  );

  modport slave (
    input  stall, PCsrc, Result, ImmOp,
    output PC, ras_count, ras_overflow, ras_underflow, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with stall, call/return via a circular return-address
// stack, and target alignment checking. All outputs are registered.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                INSTR_BYTES  = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
);
  localparam int               PW   = $clog2(RAS_DEPTH);
  localparam int               CW   = PW + 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] LOWM = WIDTH'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]    FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMPR  = 3'd2,
    SRC_CALL   = 3'd3,
    SRC_RET    = 3'd4
  } pcsrc_e;

  logic [WIDTH-1:0] pc_q, seq_pc, tgt, ras_top;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;   // next free slot; top entry lives at ptr_q-1
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, und_q, mis_q;
  logic             push, pop, und_d;

  assign seq_pc  = pc_q + STEP;
  assign ras_top = ras_mem[ptr_q - PW'(1)];

  always_comb begin
    tgt   = seq_pc;
    push  = 1'b0;
    pop   = 1'b0;
    und_d = 1'b0;
    case (bus.PCsrc)
      SRC_BRANCH: tgt = pc_q + bus.ImmOp;
      SRC_JUMPR:  tgt = bus.Result;
      SRC_CALL: begin
        tgt  = pc_q + bus.ImmOp;
        push = 1'b1;
      end
      SRC_RET: begin
        if (cnt_q == '0) begin
          tgt   = bus.Result;
          und_d = 1'b1;
        end else begin
          tgt = ras_top;
          pop = 1'b1;
        end
      end
      default: tgt = seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      und_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (bus.stall) begin
      und_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= tgt & ~LOWM;
      und_q <= und_d;
      mis_q <= |(tgt & LOWM);
      // a push on a full stack wraps the pointer onto the oldest entry
      if (push) begin
        ptr_q <= ptr_q + PW'(1);
        if (cnt_q == FULL) ovf_q <= 1'b1;
        else               cnt_q <= cnt_q + CW'(1);
      end else if (pop) begin
        ptr_q <= ptr_q - PW'(1);
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && push) ras_mem[ptr_q] <= seq_pc;
  end

  assign bus.PC            = pc_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = und_q;
  assign bus.misaligned    = mis_q;
endmodule
